coeff_loader: RTL and testbench

//  Write side of the FIR coefficient memory: the address counter walks the coefficient memory to read
//  it, and this block fills it. Consumes the UART RX byte stream, assembles bytes into COEFF_WIDTH-bit

---
 rtl/coeff_loader.sv | 129 ++++++++++++
 tb/tb_coeff_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/coeff_loader.sv
// Write side of the FIR coefficient memory: packs received UART bytes (MSB byte first)
// into coefficients and writes them to sequential addresses, reporting done or timeout.
module coeff_loader #(
    parameter int COEFF_COUNT    = 64,
    parameter int COEFF_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int ADDR_W = (COEFF_COUNT > 1) ? $clog2(COEFF_COUNT) : 1,
    localparam int NBYTES = (COEFF_WIDTH + 7) / 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [COEFF_WIDTH-1:0] wr_data,
    output logic                   busy,
    output logic                   done,
    output logic                   loaded,
    output logic                   error,
    output logic [1:0]             dbg_state
);

    localparam int ASM_W = NBYTES * 8;
    localparam int CNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  LAST_BYTE  = CNT_W'(NBYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(COEFF_COUNT - 1);
    localparam logic [TMR_W-1:0]  LAST_TICK  = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] index;
    logic [CNT_W-1:0]  byte_cnt;
    logic [TMR_W-1:0]  timer;
    logic [ASM_W-1:0]  asm_reg;
    logic [ASM_W-1:0]  asm_next;

    // Handshake: rx_valid is a one-cycle strobe with no ready/backpressure; every strobe
    // seen in LOAD is consumed that same cycle, outside LOAD it is dropped.
    always_comb begin
        asm_next = (asm_reg << 8) | ASM_W'(rx_data);
    end

    assign dbg_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            index    <= '0;
            byte_cnt <= '0;
            timer    <= '0;
            asm_reg  <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            loaded   <= 1'b0;
            error    <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        index    <= '0;
                        byte_cnt <= '0;
                        timer    <= '0;
                        asm_reg  <= '0;
                        loaded   <= 1'b0;
                        error    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (rx_valid) begin
                        asm_reg <= asm_next;
                        timer   <= '0;
                        if (byte_cnt == LAST_BYTE) begin
                            // Excess high bits of the first byte fall off here.
                            byte_cnt <= '0;
                            wr_en    <= 1'b1;
                            wr_addr  <= index;
                            wr_data  <= asm_next[COEFF_WIDTH-1:0];
                            if (index == LAST_INDEX) begin
                                state  <= DONE;
                                busy   <= 1'b0;
                                done   <= 1'b1;
                                loaded <= 1'b1;
                            end else begin
                                index <= index + ADDR_W'(1);
                            end
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end else if (TIMEOUT_CYCLES != 0) begin
                        if (timer == LAST_TICK) begin
                            // Abandon the load; any partial coefficient is thrown away.
                            state    <= IDLE;
                            busy     <= 1'b0;
                            error    <= 1'b1;
                            byte_cnt <= '0;
                            asm_reg  <= '0;
                            timer    <= '0;
                        end else begin
                            timer <= timer + TMR_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coeff_loader.sv
// Directed bench for coeff_loader: a 4 x 16-bit instance with a 20-cycle timeout,
// plus a 12-bit instance to cover truncation of the first byte.
module tb_coeff_loader;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    logic        loaded;
    logic        error;
    logic [1:0]  dbg_state;

    logic        start12;
    logic        rx_valid12;
    logic        wr_en12;
    logic [1:0]  wr_addr12;
    logic [11:0] wr_data12;
    logic        busy12;
    logic        done12;
    logic        loaded12;
    logic        error12;
    logic [1:0]  dbg_state12;

    coeff_loader #(.COEFF_COUNT(4), .COEFF_WIDTH(16), .TIMEOUT_CYCLES(20)) dut (
        .clock(clock), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done),
        .loaded(loaded), .error(error), .dbg_state(dbg_state)
    );

    coeff_loader #(.COEFF_COUNT(4), .COEFF_WIDTH(12), .TIMEOUT_CYCLES(20)) dut12 (
        .clock(clock), .reset(reset), .start(start12), .rx_data(rx_data), .rx_valid(rx_valid12),
        .wr_en(wr_en12), .wr_addr(wr_addr12), .wr_data(wr_data12), .busy(busy12), .done(done12),
        .loaded(loaded12), .error(error12), .dbg_state(dbg_state12)
    );

    logic [7:0]  bytes  [8] = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    logic [15:0] coeffs [4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};

    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];
    logic [13:0] got12_q[$];
    int vectors     = 0;
    int miscompares = 0;
    int done_pulses = 0;

    // Write monitor samples on the falling edge, away from the active edge.
    always @(negedge clock) begin
        if (wr_en) got_q.push_back({wr_addr, wr_data});
        if (done) done_pulses++;
        if (wr_en12) got12_q.push_back({wr_addr12, wr_data12});
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push_full_load();
        for (int i = 0; i < 4; i++) exp_q.push_back({2'(i), coeffs[i]});
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %0b want 0", wr_en); end
        vectors++; if (wr_addr !== 2'd0) begin miscompares++; $display("FAIL reset_wr_addr: got %0h want 0", wr_addr); end
        vectors++; if (wr_data !== 16'h0) begin miscompares++; $display("FAIL reset_wr_data: got %0h want 0", wr_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %0b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b want 0", done); end
        vectors++; if (loaded !== 1'b0) begin miscompares++; $display("FAIL reset_loaded: got %0b want 0", loaded); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL reset_error: got %0b want 0", error); end
        vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_load_with_gaps();
        done_pulses = 0;
        pulse_start();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL gaps_busy: got %0b want 1", busy); end
        for (int i = 0; i < 8; i++) begin
            send_byte(bytes[i]);
            if (i == 7) begin
                vectors++; if (wr_en !== 1'b1) begin miscompares++; $display("FAIL gaps_last_we: got %0b want 1", wr_en); end
                vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL gaps_done: got %0b want 1", done); end
                vectors++; if (loaded !== 1'b1) begin miscompares++; $display("FAIL gaps_loaded: got %0b want 1", loaded); end
                vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL gaps_busy_end: got %0b want 0", busy); end
                vectors++; if (dbg_state !== 2'd2) begin miscompares++; $display("FAIL gaps_state_done: got %0d want 2", dbg_state); end
            end else begin
                tick();
                tick();
                if (i % 2 == 1) begin
                    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL gaps_we_low: got %0b want 0", wr_en); end
                    vectors++; if (wr_data !== coeffs[i/2]) begin miscompares++; $display("FAIL gaps_hold: got %0h want %0h", wr_data, coeffs[i/2]); end
                end
            end
        end
        tick();
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL gaps_done_pulse: got %0b want 0", done); end
        vectors++; if (loaded !== 1'b1) begin miscompares++; $display("FAIL gaps_loaded_level: got %0b want 1", loaded); end
        vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL gaps_state_idle: got %0d want 0", dbg_state); end
        vectors++; if (done_pulses !== 1) begin miscompares++; $display("FAIL gaps_done_count: got %0d want 1", done_pulses); end
        push_full_load();
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL gaps_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL gaps_write%0d: got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic want_we;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            send_byte(bytes[i]);
            want_we = (i % 2 == 1);
            vectors++; if (wr_en !== want_we) begin miscompares++; $display("FAIL b2b_we%0d: got %0b want %0b", i, wr_en, want_we); end
            if (want_we) begin
                vectors++; if (wr_addr !== 2'(i/2)) begin miscompares++; $display("FAIL b2b_addr%0d: got %0d want %0d", i, wr_addr, i/2); end
                vectors++; if (wr_data !== coeffs[i/2]) begin miscompares++; $display("FAIL b2b_data%0d: got %0h want %0h", i, wr_data, coeffs[i/2]); end
            end
        end
        tick();
        push_full_load();
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL b2b_write%0d: got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_timeout();
        pulse_start();
        vectors++; if (loaded !== 1'b0) begin miscompares++; $display("FAIL to_loaded_cleared: got %0b want 0", loaded); end
        for (int i = 0; i < 3; i++) send_byte(bytes[i]);
        repeat (19) tick();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL to_busy_19: got %0b want 1", busy); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL to_error_19: got %0b want 0", error); end
        tick();
        vectors++; if (error !== 1'b1) begin miscompares++; $display("FAIL to_error: got %0b want 1", error); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL to_busy: got %0b want 0", busy); end
        vectors++; if (loaded !== 1'b0) begin miscompares++; $display("FAIL to_loaded: got %0b want 0", loaded); end
        repeat (3) tick();
        exp_q.push_back({2'd0, 16'h1234});
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL to_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL to_write%0d: got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_ignored_inputs();
        done_pulses = 0;
        send_byte(8'hAA);
        tick();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ign_idle_busy: got %0b want 0", busy); end
        vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL ign_idle_write: got %0d want 0", got_q.size()); end
        start = 1'b1;
        send_byte(8'h55);
        start = 1'b0;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL ign_start_busy: got %0b want 1", busy); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL ign_error_cleared: got %0b want 0", error); end
        vectors++; if (dbg_state !== 2'd1) begin miscompares++; $display("FAIL ign_state_load: got %0d want 1", dbg_state); end
        start = 1'b1;
        send_byte(bytes[0]);
        start = 1'b0;
        for (int i = 1; i < 8; i++) send_byte(bytes[i]);
        tick();
        vectors++; if (loaded !== 1'b1) begin miscompares++; $display("FAIL ign_loaded: got %0b want 1", loaded); end
        vectors++; if (done_pulses !== 1) begin miscompares++; $display("FAIL ign_done_count: got %0d want 1", done_pulses); end
        push_full_load();
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL ign_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL ign_write%0d: got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_load();
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(bytes[i]);
        tick();
        got_q.delete();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL rst_wr_en: got %0b want 0", wr_en); end
        vectors++; if (wr_addr !== 2'd0) begin miscompares++; $display("FAIL rst_wr_addr: got %0h want 0", wr_addr); end
        vectors++; if (wr_data !== 16'h0) begin miscompares++; $display("FAIL rst_wr_data: got %0h want 0", wr_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %0b want 0", busy); end
        vectors++; if (loaded !== 1'b0) begin miscompares++; $display("FAIL rst_loaded: got %0b want 0", loaded); end
        vectors++; if (error !== 1'b0) begin miscompares++; $display("FAIL rst_error: got %0b want 0", error); end
        send_byte(bytes[5]);
        send_byte(bytes[6]);
        tick();
        vectors++; if (got_q.size() != 0) begin miscompares++; $display("FAIL rst_no_write: got %0d want 0", got_q.size()); end
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(bytes[i]);
        tick();
        vectors++; if (loaded !== 1'b1) begin miscompares++; $display("FAIL rst_reload_loaded: got %0b want 1", loaded); end
        push_full_load();
        vectors++; if (got_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rst_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vectors++; if (got_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rst_write%0d: got %0h want %0h", i, got_q[i], exp_q[i]); end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_width12();
        start12 = 1'b1;
        tick();
        start12 = 1'b0;
        vectors++; if (busy12 !== 1'b1) begin miscompares++; $display("FAIL w12_busy: got %0b want 1", busy12); end
        rx_data    = 8'hF1;
        rx_valid12 = 1'b1;
        tick();
        rx_data = 8'h23;
        tick();
        rx_valid12 = 1'b0;
        vectors++; if (wr_en12 !== 1'b1) begin miscompares++; $display("FAIL w12_we: got %0b want 1", wr_en12); end
        vectors++; if (wr_addr12 !== 2'd0) begin miscompares++; $display("FAIL w12_addr: got %0d want 0", wr_addr12); end
        vectors++; if (wr_data12 !== 12'h123) begin miscompares++; $display("FAIL w12_data: got %0h want 123", wr_data12); end
        tick();
        vectors++; if (got12_q.size() != 1) begin miscompares++; $display("FAIL w12_count: got %0d want 1", got12_q.size()); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        start12    = 1'b0;
        rx_valid12 = 1'b0;
        test_reset();
        test_load_with_gaps();
        test_back_to_back();
        test_timeout();
        test_ignored_inputs();
        test_reset_mid_load();
        test_width12();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
